// File: rtl/eth_apb_mem_pkg.sv
// Shared types and constants for the APB memory responder used as the MAC's DMA target.
package eth_apb_mem_pkg;

  localparam int unsigned DATA_W              = 32;
  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned CNT_W               = 16;
  localparam int unsigned WAIT_W              = 4;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  // Request captured at SETUP and held for the whole access phase.
  typedef struct packed {
    logic              write;
    logic              err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  function automatic logic [ADDR_W-1:0] word_offset(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/eth_apb_mem_array.sv
// Word RAM: one write port (APB beats backdoor), registered APB read, combinational backdoor read.
module eth_apb_mem_array
  import eth_apb_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           apb_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] apb_idx,
  input  logic [DATA_W-1:0]              apb_wdata,
  input  logic                           bd_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] bd_idx,
  input  logic [DATA_W-1:0]              bd_wdata,
  input  logic                           rd_load,
  input  logic                           rd_clr,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output logic [DATA_W-1:0]              rd_data,
  output logic [DATA_W-1:0]              bd_rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic              we;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    we    = apb_we | bd_we;
    widx  = apb_we ? apb_idx   : bd_idx;
    wdata = apb_we ? apb_wdata : bd_wdata;
  end

  // Contents survive reset so preloaded frames/descriptors stay valid.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data <= '0;
    else if (rd_load) rd_data <= rd_clr ? '0 : mem[rd_idx];
  end

  assign bd_rdata = mem[bd_idx];

endmodule

// File: rtl/eth_apb_mem_responder.sv
// APB3 slave memory answering the Ethernet MAC DMA master, with programmable wait states.
module eth_apb_mem_responder
  import eth_apb_mem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                           pclk_i,
  input  logic                           prstn_i,
  input  logic                           psel_i,
  input  logic                           penable_i,
  input  logic                           pwrite_i,
  input  logic [ADDR_W-1:0]              paddr_i,
  input  logic [DATA_W-1:0]              pwdata_i,
  output logic [DATA_W-1:0]              prdata_o,
  output logic                           pready_o,
  output logic                           pslverr_o,
  input  logic [WAIT_W-1:0]              wait_i,
  input  logic                           bd_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] bd_addr_i,
  input  logic [DATA_W-1:0]              bd_wdata_i,
  output logic [DATA_W-1:0]              bd_rdata_o,
  output logic [CNT_W-1:0]               wr_cnt_o,
  output logic [CNT_W-1:0]               rd_cnt_o,
  output logic                           proto_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t            state, state_d;
  logic [WAIT_W-1:0] cnt, cnt_d;
  logic              ready_d, slverr_d, proto_d;
  logic [CNT_W-1:0]  wr_cnt_d, rd_cnt_d;
  apb_req_t          req, req_d;
  logic [ADDR_W-1:0] dec_off;
  logic              dec_err;
  logic              rd_load, commit;

  // Address decode of the bus as presented in SETUP.
  always_comb begin
    dec_off = word_offset(paddr_i, BASE_ADDR);
    dec_err = (paddr_i[1:0] != 2'b00) || (paddr_i < BASE_ADDR) ||
              (dec_off >= ADDR_W'(DEPTH_WORDS));
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    ready_d  = pready_o;
    slverr_d = pslverr_o;
    req_d    = req;
    wr_cnt_d = wr_cnt_o;
    rd_cnt_d = rd_cnt_o;
    proto_d  = proto_err_o;
    rd_load  = 1'b0;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          state_d     = ST_ACCESS;
          cnt_d       = wait_i;
          ready_d     = (wait_i == '0);
          slverr_d    = dec_err && (wait_i == '0);
          req_d.write = pwrite_i;
          req_d.err   = dec_err;
          req_d.addr  = paddr_i;
          req_d.wdata = pwdata_i;
          rd_load     = !pwrite_i;
        end else if (psel_i && penable_i) begin
          proto_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!psel_i) begin
          state_d  = ST_IDLE;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
        end else begin
          if ((paddr_i != req.addr) || (pwrite_i != req.write) || (pwdata_i != req.wdata))
            proto_d = 1'b1;
          if (!pready_o) begin
            cnt_d    = cnt - WAIT_W'(1);
            ready_d  = (cnt == WAIT_W'(1));
            slverr_d = req.err && (cnt == WAIT_W'(1));
          end else if (penable_i) begin
            state_d  = ST_IDLE;
            ready_d  = 1'b0;
            slverr_d = 1'b0;
            if (!req.err) begin
              if (req.write) begin
                commit   = 1'b1;
                wr_cnt_d = sat_inc(wr_cnt_o);
              end else begin
                rd_cnt_d = sat_inc(rd_cnt_o);
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pready_o    <= 1'b0;
      pslverr_o   <= 1'b0;
      req         <= '0;
      wr_cnt_o    <= '0;
      rd_cnt_o    <= '0;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pready_o    <= ready_d;
      pslverr_o   <= slverr_d;
      req         <= req_d;
      wr_cnt_o    <= wr_cnt_d;
      rd_cnt_o    <= rd_cnt_d;
      proto_err_o <= proto_d;
    end
  end

  eth_apb_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk       (pclk_i),
    .rst_n     (prstn_i),
    .apb_we    (commit),
    .apb_idx   (IDX_W'(word_offset(req.addr, BASE_ADDR))),
    .apb_wdata (req.wdata),
    .bd_we     (bd_we_i),
    .bd_idx    (bd_addr_i),
    .bd_wdata  (bd_wdata_i),
    .rd_load   (rd_load),
    .rd_clr    (dec_err),
    .rd_idx    (IDX_W'(dec_off)),
    .rd_data   (prdata_o),
    .bd_rdata  (bd_rdata_o)
  );

endmodule

// File: tb/tb_eth_apb_mem_responder.sv
// Directed bench for eth_apb_mem_responder with a transaction-level memory/counter model.
module tb_eth_apb_mem_responder;

  logic        clk = 1'b0;
  logic        prstn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [3:0]  wait_v = '0;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_wdata = '0;
  logic [31:0] bd_rdata_o;
  logic [15:0] wr_cnt_o, rd_cnt_o;
  logic        proto_err_o;

  always #5 clk = ~clk;

  eth_apb_mem_responder dut (
    .pclk_i(clk), .prstn_i(prstn), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o), .wait_i(wait_v), .bd_we_i(bd_we), .bd_addr_i(bd_addr),
    .bd_wdata_i(bd_wdata), .bd_rdata_o(bd_rdata_o), .wr_cnt_o(wr_cnt_o),
    .rd_cnt_o(rd_cnt_o), .proto_err_o(proto_err_o)
  );

  // Model state
  logic [31:0] mem_m [1024];
  int          n_wr = 0, n_rd = 0;
  logic        exp_pready = 1'b0, exp_pslverr = 1'b0, exp_proto = 1'b0, exp_rd_vld = 1'b0;
  logic [31:0] exp_prdata = '0;
  logic        chk_en = 1'b0;
  int          vectors = 0, miscompares = 0;
  int          cap_k;
  logic [31:0] cap_rdata;
  logic        cap_err;

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic addr_bad(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < 32'h1000) return 1'b1;
    return ((a - 32'h1000) / 4) >= 1024;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pready", 32'(pready_o), 32'(exp_pready));
      chk("pslverr", 32'(pslverr_o), 32'(exp_pslverr));
      if (exp_rd_vld) chk("prdata", prdata_o, exp_prdata);
      chk("wr_cnt", {16'h0, wr_cnt_o}, {16'h0, sat16(n_wr)});
      chk("rd_cnt", {16'h0, rd_cnt_o}, {16'h0, sat16(n_rd)});
      chk("proto_err", 32'(proto_err_o), 32'(exp_proto));
      chk("bd_rdata", bd_rdata_o, mem_m[bd_addr]);
    end
  end

  task automatic bd_write(input int idx, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = 10'(idx); bd_wdata = d;
    @(posedge clk); #1;
    mem_m[idx] = d;
    bd_we = 1'b0; bd_addr = '0;
  endtask

  // Full APB transfer; starts and ends just after a rising edge.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                          input int w, input int abort_after, input logic bd_same,
                          input logic glitch);
    logic err;
    int   idx;
    err = addr_bad(addr);
    idx = err ? 0 : int'((addr - 32'h1000) >> 2);
    cap_k = 0; cap_rdata = 'x; cap_err = 1'bx;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; wait_v = 4'(w);
    @(posedge clk); #1;
    penable = 1'b1;
    if (!wr) begin
      exp_prdata = err ? 32'h0 : mem_m[idx];
      exp_rd_vld = 1'b1;
    end
    for (int k = 1; k <= w + 1; k++) begin
      exp_pready  = (k == w + 1);
      exp_pslverr = err && (k == w + 1);
      if (k == abort_after + 1) begin psel = 1'b0; penable = 1'b0; end
      if (glitch && k == 1) paddr = addr ^ 32'h4;
      if (bd_same && k == w + 1) begin bd_we = 1'b1; bd_addr = 10'(idx); bd_wdata = ~data; end
      @(negedge clk);
      if (pready_o && cap_k == 0) begin cap_k = k; cap_rdata = prdata_o; cap_err = pslverr_o; end
      @(posedge clk); #1;
      if (glitch && k == 1) exp_proto = 1'b1;
      if (k == abort_after + 1) begin
        exp_pready = 1'b0; exp_pslverr = 1'b0; exp_rd_vld = 1'b0;
        return;
      end
    end
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_rd_vld = 1'b0;
    bd_we = 1'b0;
    if (!err) begin
      if (wr) begin mem_m[idx] = data; n_wr++; end
      else n_rd++;
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic model_reset();
    n_wr = 0; n_rd = 0; exp_proto = 1'b0;
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_rd_vld = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prdata", prdata_o, 32'h0);
    chk("rst_pready", 32'(pready_o), 32'h0);
    chk("rst_pslverr", 32'(pslverr_o), 32'h0);
    chk("rst_cnts", {wr_cnt_o, rd_cnt_o}, 32'h0);
    chk("rst_proto", 32'(proto_err_o), 32'h0);

    // Preload every word so backdoor reads are fully modelled.
    for (int i = 0; i < 1024; i++) begin
      bd_we = 1'b1; bd_addr = 10'(i); bd_wdata = 32'hC0DE_0000 | 32'(i);
      mem_m[i] = 32'hC0DE_0000 | 32'(i);
      @(posedge clk); #1;
    end
    bd_we = 1'b0; bd_addr = '0;
    prstn = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read of a backdoor-loaded word
    bd_write(5, 32'hDEAD_BEEF);
    apb_xfer(32'h1014, 1'b0, 32'h0, 0, -1, 1'b0, 1'b0);
    chk("rd5_ready_cycle", 32'(cap_k), 32'd1);
    chk("rd5_data", cap_rdata, 32'hDEAD_BEEF);
    chk("rd5_rd_cnt", {16'h0, rd_cnt_o}, 32'd1);

    // Three wait states on a write
    apb_xfer(32'h1000, 1'b1, 32'h1234_5678, 3, -1, 1'b0, 1'b0);
    chk("wr0_ready_cycle", 32'(cap_k), 32'd4);
    chk("wr0_bd", bd_rdata_o, 32'h1234_5678);
    chk("wr0_wr_cnt", {16'h0, wr_cnt_o}, 32'd1);

    // Decode errors: misaligned, past the end, below base
    apb_xfer(32'h1002, 1'b0, 32'h0, 1, -1, 1'b0, 1'b0);
    chk("err_mis_slverr", 32'(cap_err), 32'd1);
    chk("err_mis_data", cap_rdata, 32'h0);
    apb_xfer(32'h2000, 1'b0, 32'h0, 0, -1, 1'b0, 1'b0);
    chk("err_oob_slverr", 32'(cap_err), 32'd1);
    chk("err_oob_data", cap_rdata, 32'h0);
    apb_xfer(32'h0FFC, 1'b1, 32'hFFFF_FFFF, 0, -1, 1'b0, 1'b0);
    chk("err_cnts", {wr_cnt_o, rd_cnt_o}, 32'h0001_0001);

    // Abort after two access cycles, then a normal back-to-back read
    apb_xfer(32'h1008, 1'b1, 32'hBAD0_BAD0, 5, 2, 1'b0, 1'b0);
    chk("abort_no_ready", 32'(cap_k), 32'd0);
    apb_xfer(32'h1008, 1'b0, 32'h0, 2, -1, 1'b0, 1'b0);
    chk("abort_word2", cap_rdata, 32'hC0DE_0002);
    chk("abort_wr_cnt", {16'h0, wr_cnt_o}, 32'd1);

    // ACCESS phase without SETUP
    psel = 1'b1; penable = 1'b1; paddr = 32'h1000; pwrite = 1'b0;
    @(posedge clk); #1;
    exp_proto = 1'b1;
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("proto_sticky", 32'(proto_err_o), 32'd1);
    prstn = 1'b0;
    model_reset();
    #1;
    chk("proto_cleared", 32'(proto_err_o), 32'd0);
    @(posedge clk); #1;
    prstn = 1'b1;
    chk("mem_kept", bd_rdata_o, 32'h1234_5678);

    // Address changes mid-access: flag raised, latched address written
    apb_xfer(32'h1010, 1'b1, 32'h0BAD_F00D, 1, -1, 1'b0, 1'b1);
    chk("glitch_proto", 32'(proto_err_o), 32'd1);
    bd_addr = 10'd4; #1;
    chk("glitch_word4", bd_rdata_o, 32'h0BAD_F00D);
    bd_addr = 10'd5; #1;
    chk("glitch_word5", bd_rdata_o, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Reset during a pending write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h100C; pwdata = 32'hFFFF_0000; wait_v = 4'd3;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    prstn = 1'b0;
    model_reset();
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    prstn = 1'b1;
    bd_addr = 10'd3; #1;
    chk("rst_mid_word3", bd_rdata_o, 32'hC0DE_0003);
    @(posedge clk); #1;

    // Saturate the read counter
    for (int i = 0; i < 65540; i++)
      apb_xfer(32'h1000 + 32'(4 * (i % 1024)), 1'b0, 32'h0, 0, -1, 1'b0, 1'b0);
    chk("rd_cnt_sat", {16'h0, rd_cnt_o}, 32'h0000_FFFF);

    // Backdoor and APB writing word 7 on the same edge
    apb_xfer(32'h101C, 1'b1, 32'h7777_AAAA, 0, -1, 1'b1, 1'b0);
    bd_addr = 10'd7; #1;
    chk("same_edge_word7", bd_rdata_o, 32'h7777_AAAA);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
